// File: rtl/hazard3_ahb_arb_nport_pkg.sv
// Shared AHB-Lite constants and arbitration-mode type for the N-port load/store arbiter.
package hazard3_ahb_arb_nport_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;

  // Data access, user mode, non-bufferable, non-cacheable; privilege bit is OR'd in by the arbiter.
  localparam logic [3:0] HPROT_DATA = 4'b0001;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

endpackage

// File: rtl/hazard3_arb_rr_pick.sv
// One-hot request picker: lowest index first (fixed) or first request after ptr (round-robin).
module hazard3_arb_rr_pick
  import hazard3_ahb_arb_nport_pkg::*;
#(
  parameter int unsigned N_PORTS = 3,
  parameter int unsigned W_PTR   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [W_PTR-1:0]   ptr,
  input  arb_mode_t          mode,
  output logic [N_PORTS-1:0] gnt
);

  logic [31:0] idx;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (mode == ARB_RR) begin
        idx = (32'(ptr) + 32'd1 + k) % N_PORTS;
      end else begin
        idx = k;
      end
      if (!found && req[idx[W_PTR-1:0]]) begin
        gnt[idx[W_PTR-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard3_ahb_arb_nport.sv
// N-to-1 AHB-Lite arbiter for the load/store side (core D port, SBA, other masters).
// Optional per-port wait-cycle counters: define HAZARD3_ARB_PERF_CNT_EN.
module hazard3_ahb_arb_nport
  import hazard3_ahb_arb_nport_pkg::*;
#(
  parameter int unsigned         N_PORTS     = 3,
  parameter int unsigned         W_ADDR      = 32,
  parameter int unsigned         W_DATA      = 32,
  parameter int unsigned         ROUND_ROBIN = 0,
  parameter logic [N_PORTS-1:0]  HOLD_MASK   = 3'b110,
  parameter int unsigned         W_PERF      = 16
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [N_PORTS-1:0]          up_aph_req,
  output logic [N_PORTS-1:0]          up_aph_ready,
  input  logic [N_PORTS*W_ADDR-1:0]   up_haddr,
  input  logic [N_PORTS-1:0]          up_hwrite,
  input  logic [N_PORTS*3-1:0]        up_hsize,
  input  logic [N_PORTS-1:0]          up_hexcl,
  input  logic [N_PORTS-1:0]          up_priv,
  input  logic [N_PORTS*W_DATA-1:0]   up_wdata,
  output logic [N_PORTS-1:0]          up_dph_ready,
  output logic [N_PORTS-1:0]          up_dph_err,
  output logic [N_PORTS-1:0]          up_dph_exokay,
  output logic [W_DATA-1:0]           up_rdata,

  output logic [W_ADDR-1:0]           haddr,
  output logic                        hwrite,
  output logic [1:0]                  htrans,
  output logic [2:0]                  hsize,
  output logic [2:0]                  hburst,
  output logic [3:0]                  hprot,
  output logic                        hmastlock,
  output logic                        hexcl,
  input  logic                        hready,
  input  logic                        hresp,
  input  logic                        hexokay,
  output logic [W_DATA-1:0]           hwdata,
  input  logic [W_DATA-1:0]           hrdata
`ifdef HAZARD3_ARB_PERF_CNT_EN
  ,
  input  logic                        perf_clr,
  output logic [N_PORTS*W_PERF-1:0]   perf_wait
`endif
);

  localparam int unsigned W_PTR = $clog2(N_PORTS);
  localparam arb_mode_t   MODE  = (ROUND_ROBIN != 0) ? ARB_RR : ARB_FIXED;

  logic                 hold_aph;
  logic [N_PORTS-1:0]   gnt_prev;
  logic [N_PORTS-1:0]   dph_owner;
  logic [W_PTR-1:0]     rr_ptr;

  logic [N_PORTS-1:0]   req_eff;
  logic [N_PORTS-1:0]   pick_gnt;
  logic [N_PORTS-1:0]   gnt;
  logic [W_PTR-1:0]     gnt_idx;
  logic                 priv_sel;

  // Held-request masters must not be re-granted while their own data phase is outstanding.
  assign req_eff = up_aph_req & ~(HOLD_MASK & dph_owner);

  hazard3_arb_rr_pick #(
    .N_PORTS (N_PORTS),
    .W_PTR   (W_PTR)
  ) u_pick (
    .req  (req_eff),
    .ptr  (rr_ptr),
    .mode (MODE),
    .gnt  (pick_gnt)
  );

  // A stalled address phase keeps its grant; reset suppresses any new transfer.
  assign gnt = rst ? '0 : (hold_aph ? gnt_prev : pick_gnt);

  always_comb begin
    haddr    = '0;
    hwrite   = 1'b0;
    hsize    = '0;
    hexcl    = 1'b0;
    priv_sel = 1'b0;
    hwdata   = '0;
    gnt_idx  = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      haddr    = haddr  | ({W_ADDR{gnt[i]}} & up_haddr[i*W_ADDR +: W_ADDR]);
      hwrite   = hwrite   | (gnt[i] & up_hwrite[i]);
      hsize    = hsize  | ({3{gnt[i]}} & up_hsize[i*3 +: 3]);
      hexcl    = hexcl    | (gnt[i] & up_hexcl[i]);
      priv_sel = priv_sel | (gnt[i] & up_priv[i]);
      hwdata   = hwdata | ({W_DATA{dph_owner[i]}} & up_wdata[i*W_DATA +: W_DATA]);
      gnt_idx  = gnt_idx | ({W_PTR{gnt[i]}} & W_PTR'(i));
    end
  end

  assign htrans    = (|gnt) ? HTRANS_NSEQ : HTRANS_IDLE;
  assign hprot     = HPROT_DATA | {2'b00, priv_sel, 1'b0};
  assign hburst    = 3'h0;
  assign hmastlock = 1'b0;

  assign up_aph_ready  = {N_PORTS{hready}} & gnt;
  assign up_dph_ready  = rst ? '0 : (dph_owner & {N_PORTS{hready}});
  assign up_dph_err    = rst ? '0 : (dph_owner & {N_PORTS{hresp}});
  assign up_dph_exokay = rst ? '0 : (dph_owner & {N_PORTS{hexokay}});
  assign up_rdata      = hrdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_aph  <= 1'b0;
      gnt_prev  <= '0;
      dph_owner <= '0;
      rr_ptr    <= '0;
    end else begin
      // Error response releases the hold so a pipelined follower can be withdrawn.
      hold_aph <= htrans[1] && !hready && !hresp;
      gnt_prev <= gnt;
      if (hready) begin
        dph_owner <= gnt;
        if (|gnt) begin
          rr_ptr <= gnt_idx;
        end
      end
    end
  end

`ifdef HAZARD3_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (rst || perf_clr) begin
        perf_wait[i*W_PERF +: W_PERF] <= '0;
      end else if (up_aph_req[i] && !up_aph_ready[i] &&
                   (perf_wait[i*W_PERF +: W_PERF] != '1)) begin
        perf_wait[i*W_PERF +: W_PERF] <= perf_wait[i*W_PERF +: W_PERF] + W_PERF'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard3_ahb_arb_nport.sv
// Randomized bench: fixed-priority and round-robin arbiters against an index-based rule model.
module tb_hazard3_ahb_arb_nport;

  localparam int N  = 3;
  localparam int WA = 32;
  localparam int WD = 32;
  localparam int WP = 16;
  localparam logic [N-1:0] HOLD = 3'b110;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      up_aph_req;
  logic [N*WA-1:0]   up_haddr;
  logic [N-1:0]      up_hwrite;
  logic [N*3-1:0]    up_hsize;
  logic [N-1:0]      up_hexcl;
  logic [N-1:0]      up_priv;
  logic [N*WD-1:0]   up_wdata;
  logic              hready;
  logic              hresp;
  logic              hexokay;
  logic [WD-1:0]     hrdata;
  logic              perf_clr;

  logic [N-1:0]      o_aph_ready  [2];
  logic [N-1:0]      o_dph_ready  [2];
  logic [N-1:0]      o_dph_err    [2];
  logic [N-1:0]      o_dph_exokay [2];
  logic [WD-1:0]     o_rdata      [2];
  logic [WA-1:0]     o_haddr      [2];
  logic              o_hwrite     [2];
  logic [1:0]        o_htrans     [2];
  logic [2:0]        o_hsize      [2];
  logic [2:0]        o_hburst     [2];
  logic [3:0]        o_hprot      [2];
  logic              o_hmastlock  [2];
  logic              o_hexcl      [2];
  logic [WD-1:0]     o_hwdata     [2];
  logic [N*WP-1:0]   o_perf       [2];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    hazard3_ahb_arb_nport #(
      .N_PORTS     (N),
      .W_ADDR      (WA),
      .W_DATA      (WD),
      .ROUND_ROBIN (m),
      .HOLD_MASK   (HOLD),
      .W_PERF      (WP)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .up_aph_req    (up_aph_req),
      .up_aph_ready  (o_aph_ready[m]),
      .up_haddr      (up_haddr),
      .up_hwrite     (up_hwrite),
      .up_hsize      (up_hsize),
      .up_hexcl      (up_hexcl),
      .up_priv       (up_priv),
      .up_wdata      (up_wdata),
      .up_dph_ready  (o_dph_ready[m]),
      .up_dph_err    (o_dph_err[m]),
      .up_dph_exokay (o_dph_exokay[m]),
      .up_rdata      (o_rdata[m]),
      .haddr         (o_haddr[m]),
      .hwrite        (o_hwrite[m]),
      .htrans        (o_htrans[m]),
      .hsize         (o_hsize[m]),
      .hburst        (o_hburst[m]),
      .hprot         (o_hprot[m]),
      .hmastlock     (o_hmastlock[m]),
      .hexcl         (o_hexcl[m]),
      .hready        (hready),
      .hresp         (hresp),
      .hexokay       (hexokay),
      .hwdata        (o_hwdata[m]),
      .hrdata        (hrdata)
`ifdef HAZARD3_ARB_PERF_CNT_EN
      ,
      .perf_clr      (perf_clr),
      .perf_wait     (o_perf[m])
`endif
    );
  end

  // Reference state: port indices (-1 = none) rather than one-hot vectors
  int m_hold  [2];
  int m_prev  [2];
  int m_owner [2];
  int m_rr    [2];
  int m_perf  [2][N];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_grant(int m);
    if (rst) return -1;
    if (m_hold[m] != 0) return m_prev[m];
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m == 1) ? (m_rr[m] + 1 + k) % N : k;
      if (up_aph_req[j] && !(HOLD[j] && m_owner[m] == j)) return j;
    end
    return -1;
  endfunction

  function automatic void model_reset(int m);
    m_hold[m]  = 0;
    m_prev[m]  = -1;
    m_owner[m] = -1;
    m_rr[m]    = 0;
    for (int i = 0; i < N; i++) m_perf[m][i] = 0;
  endfunction

  task automatic check_and_step(input int m);
    int            g;
    logic [N-1:0]  e_aph, e_dr, e_de, e_dx;
    logic [WA-1:0] e_addr;
    logic [WD-1:0] e_wdata;
    logic [2:0]    e_size;
    logic          e_wr, e_ex, e_pr;
    logic [N*WP-1:0] e_perf;
    g = exp_grant(m);
    e_addr  = (g >= 0) ? up_haddr[g*WA +: WA] : '0;
    e_size  = (g >= 0) ? up_hsize[g*3 +: 3] : 3'd0;
    e_wr    = (g >= 0) ? up_hwrite[g] : 1'b0;
    e_ex    = (g >= 0) ? up_hexcl[g] : 1'b0;
    e_pr    = (g >= 0) ? up_priv[g] : 1'b0;
    e_wdata = (m_owner[m] >= 0) ? up_wdata[m_owner[m]*WD +: WD] : '0;
    for (int i = 0; i < N; i++) begin
      e_aph[i] = hready && (g == i);
      e_dr[i]  = !rst && (m_owner[m] == i) && hready;
      e_de[i]  = !rst && (m_owner[m] == i) && hresp;
      e_dx[i]  = !rst && (m_owner[m] == i) && hexokay;
      e_perf[i*WP +: WP] = WP'(m_perf[m][i]);
    end
    check_val($sformatf("m%0d.htrans", m), 64'(o_htrans[m]), (g >= 0) ? 64'd2 : 64'd0);
    check_val($sformatf("m%0d.haddr", m), 64'(o_haddr[m]), 64'(e_addr));
    check_val($sformatf("m%0d.hsize", m), 64'(o_hsize[m]), 64'(e_size));
    check_val($sformatf("m%0d.hwrite", m), 64'(o_hwrite[m]), 64'(e_wr));
    check_val($sformatf("m%0d.hexcl", m), 64'(o_hexcl[m]), 64'(e_ex));
    check_val($sformatf("m%0d.hprot", m), 64'(o_hprot[m]), 64'({2'b00, e_pr, 1'b1}));
    check_val($sformatf("m%0d.hburst_lock", m), 64'({o_hburst[m], o_hmastlock[m]}), 64'd0);
    check_val($sformatf("m%0d.aph_ready", m), 64'(o_aph_ready[m]), 64'(e_aph));
    check_val($sformatf("m%0d.dph_ready", m), 64'(o_dph_ready[m]), 64'(e_dr));
    check_val($sformatf("m%0d.dph_err", m), 64'(o_dph_err[m]), 64'(e_de));
    check_val($sformatf("m%0d.dph_exokay", m), 64'(o_dph_exokay[m]), 64'(e_dx));
    check_val($sformatf("m%0d.hwdata", m), 64'(o_hwdata[m]), 64'(e_wdata));
    check_val($sformatf("m%0d.rdata", m), 64'(o_rdata[m]), 64'(hrdata));
`ifdef HAZARD3_ARB_PERF_CNT_EN
    check_val($sformatf("m%0d.perf_wait", m), 64'(o_perf[m]), 64'(e_perf));
`endif
    // Advance the reference by one clock edge
    for (int i = 0; i < N; i++) begin
      if (rst || perf_clr) m_perf[m][i] = 0;
      else if (up_aph_req[i] && !e_aph[i] && m_perf[m][i] < 65535) m_perf[m][i]++;
    end
    if (rst) begin
      m_hold[m]  = 0;
      m_prev[m]  = -1;
      m_owner[m] = -1;
      m_rr[m]    = 0;
    end else begin
      m_hold[m] = (g >= 0 && !hready && !hresp) ? 1 : 0;
      m_prev[m] = g;
      if (hready) begin
        m_owner[m] = g;
        if (g >= 0) m_rr[m] = g;
      end
    end
  endtask

  task automatic drive(input int phase);
    rst      = (cyc < 3) || (phase == 0 && $urandom_range(0, 63) == 0);
    perf_clr = ($urandom_range(0, 49) == 0);
    for (int i = 0; i < N; i++) begin
      up_haddr[i*WA +: WA] = $urandom;
      up_wdata[i*WD +: WD] = $urandom;
      up_hsize[i*3 +: 3]   = 3'($urandom_range(0, 2));
    end
    up_hwrite = N'($urandom);
    up_hexcl  = N'($urandom);
    up_priv   = N'($urandom);
    hrdata    = $urandom;
    hexokay   = $urandom_range(0, 1) == 1;
    case (phase)
      0: begin
        up_aph_req = N'($urandom);
        hready     = $urandom_range(0, 9) < 7;
        hresp      = $urandom_range(0, 9) == 0;
      end
      1: begin
        up_aph_req = '1;
        hready     = 1'b1;
        hresp      = 1'b0;
      end
      2: begin
        up_aph_req = 3'b100;
        hready     = 1'b1;
        hresp      = 1'b0;
      end
      default: begin
        up_aph_req = N'($urandom) | 3'b001;
        hready     = $urandom_range(0, 9) < 3;
        hresp      = $urandom_range(0, 19) == 0;
      end
    endcase
  endtask

  initial begin
    rst        = 1'b1;
    perf_clr   = 1'b0;
    up_aph_req = '0;
    up_haddr   = '0;
    up_hwrite  = '0;
    up_hsize   = '0;
    up_hexcl   = '0;
    up_priv    = '0;
    up_wdata   = '0;
    hready     = 1'b1;
    hresp      = 1'b0;
    hexokay    = 1'b0;
    hrdata     = '0;
    model_reset(0);
    model_reset(1);
    for (int p = 0; p < 4; p++) begin
      int len;
      len = (p == 0) ? 500 : (p == 1) ? 120 : (p == 2) ? 60 : 300;
      for (int c = 0; c < len; c++) begin
        @(posedge clk);
        #1;
        drive(p);
        @(negedge clk);
        check_and_step(0);
        check_and_step(1);
        cyc++;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
